// File: rtl/sync_arith_pkg.sv
// sync_arith_pkg: opcode, FSM state and status-flag definitions shared by the arithmetic unit
// Exports op_e (4-bit opcode), state_e (IDLE/BUSY), ST_* status bit indices and pack_status().
package sync_arith_pkg;
  typedef enum logic [3:0] {
    OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR = 4'd3, OP_XOR = 4'd4,
    OP_SHL = 4'd5, OP_SHR = 4'd6, OP_MUL = 4'd7, OP_DIV = 4'd8, OP_REM = 4'd9
  } op_e;
  typedef enum logic {IDLE, BUSY} state_e;
  localparam int ST_Z = 0;
  localparam int ST_C = 1;
  localparam int ST_V = 2;
  localparam int ST_E = 3;
  function automatic logic [3:0] pack_status(input logic z, input logic c, input logic v, input logic e);
    logic [3:0] s;
    s = '0;
    s[ST_Z] = z;
    s[ST_C] = c;
    s[ST_V] = v;
    s[ST_E] = e;
    return s;
  endfunction
endpackage

// File: rtl/sync_arith_iter_core.sv
// sync_arith_iter_core: one-bit-per-cycle shift-add multiplier and restoring divider
// Ports: clk, i_reset (async active-low), start_i loads operands, step_i runs one iteration,
// op_i selects MUL/DIV/REM, a_i/b_i operands; done_o marks the final step, result_o is the
// value produced by that step, hi_o flags a nonzero upper product half. Divider only with SYNC_ARITH_DIV_EN.
module sync_arith_iter_core
  import sync_arith_pkg::*;
#(
  parameter int M = 32
) (
  input  logic         clk,
  input  logic         i_reset,
  input  logic         start_i,
  input  logic         step_i,
  input  logic [3:0]   op_i,
  input  logic [M-1:0] a_i,
  input  logic [M-1:0] b_i,
  output logic         done_o,
  output logic [M-1:0] result_o,
  output logic         hi_o
);
  localparam int CW = $clog2(M);
  logic [M-1:0] acc_q, acc_d, lo_q, lo_d, b_q;
  logic [CW-1:0] cnt_q;
  logic mul_q;
  logic [M:0] sum;
  assign sum = {1'b0, acc_q} + (lo_q[0] ? {1'b0, b_q} : '0);
`ifdef SYNC_ARITH_DIV_EN
  logic rem_q;
  logic [M:0] shd, diff;
  assign shd = {acc_q, lo_q[M-1]};
  assign diff = shd - {1'b0, b_q};
  // multiply shifts the product right through acc:lo; divide shifts the dividend left into acc
  assign acc_d = mul_q ? sum[M:1] : (diff[M] ? shd[M-1:0] : diff[M-1:0]);
  assign lo_d = mul_q ? {sum[0], lo_q[M-1:1]} : {lo_q[M-2:0], ~diff[M]};
  assign result_o = rem_q ? acc_d : lo_d;
`else
  assign acc_d = sum[M:1];
  assign lo_d = {sum[0], lo_q[M-1:1]};
  assign result_o = lo_d;
`endif
  assign done_o = step_i && cnt_q == CW'(M - 1);
  assign hi_o = mul_q && |acc_d;
  always_ff @(posedge clk or negedge i_reset) begin
    if (!i_reset) begin
      acc_q <= '0;
      lo_q <= '0;
      b_q <= '0;
      cnt_q <= '0;
      mul_q <= 1'b0;
`ifdef SYNC_ARITH_DIV_EN
      rem_q <= 1'b0;
`endif
    end else if (start_i) begin
      acc_q <= '0;
      lo_q <= a_i;
      b_q <= b_i;
      cnt_q <= '0;
      mul_q <= op_i == OP_MUL;
`ifdef SYNC_ARITH_DIV_EN
      rem_q <= op_i == OP_REM;
`endif
    end else if (step_i) begin
      acc_q <= acc_d;
      lo_q <= lo_d;
      cnt_q <= cnt_q + 1'b1;
    end
  end
endmodule

// File: rtl/sync_arith_unit_mc.sv
// sync_arith_unit_mc: multi-cycle arithmetic unit with single-cycle ALU ops and iterative MUL/DIV/REM
// Ports: clk, i_reset (async active-low), iarg_A/iarg_B operands, iop opcode, i_valid request,
// i_abort cancels a BUSY op; o_ready (IDLE), o_valid result pulse, o_result, o_status {E,V,C,Z}.
// Macro SYNC_ARITH_DIV_EN enables DIV/REM; otherwise opcodes 8/9 report an error.
module sync_arith_unit_mc
  import sync_arith_pkg::*;
#(
  parameter int M = 32
) (
  input  logic         clk,
  input  logic         i_reset,
  input  logic [M-1:0] iarg_A,
  input  logic [M-1:0] iarg_B,
  input  logic [3:0]   iop,
  input  logic         i_valid,
  input  logic         i_abort,
  output logic         o_ready,
  output logic         o_valid,
  output logic [M-1:0] o_result,
  output logic [3:0]   o_status
);
  localparam int LW = $clog2(M);
  state_e state_q, state_d;
  logic [M-1:0] result_q, result_d, alu_r, iter_res;
  logic [3:0] status_q, status_d;
  logic valid_q, valid_d, accept, div_op, iter_start, iter_done, iter_hi;
  logic alu_c, alu_v, alu_e;
  logic [M:0] add_w, sub_w, shl_w;
  logic [LW-1:0] sh;
  op_e op;
  assign op = op_e'(iop);
  assign sh = iarg_B[LW-1:0];
`ifdef SYNC_ARITH_DIV_EN
  assign div_op = op == OP_DIV || op == OP_REM;
`else
  assign div_op = 1'b0;
`endif
  assign accept = i_valid && state_q == IDLE;
  // a zero divisor never starts the divider; it falls through to the single-cycle error path
  assign iter_start = accept && (op == OP_MUL || (div_op && iarg_B != '0));
  assign add_w = {1'b0, iarg_A} + {1'b0, iarg_B};
  assign sub_w = {1'b0, iarg_A} - {1'b0, iarg_B};
  assign shl_w = {1'b0, iarg_A} << sh;
  always_comb begin
    alu_r = '1;
    alu_c = 1'b0;
    alu_v = 1'b0;
    alu_e = 1'b0;
    case (op)
      OP_ADD: begin
        alu_r = add_w[M-1:0];
        alu_c = add_w[M];
        alu_v = iarg_A[M-1] == iarg_B[M-1] && add_w[M-1] != iarg_A[M-1];
      end
      OP_SUB: begin
        alu_r = sub_w[M-1:0];
        alu_c = sub_w[M];
        alu_v = iarg_A[M-1] != iarg_B[M-1] && sub_w[M-1] != iarg_A[M-1];
      end
      OP_AND: alu_r = iarg_A & iarg_B;
      OP_OR:  alu_r = iarg_A | iarg_B;
      OP_XOR: alu_r = iarg_A ^ iarg_B;
      OP_SHL: begin
        alu_r = shl_w[M-1:0];
        alu_c = shl_w[M];
      end
      OP_SHR: alu_r = iarg_A >> sh;
      default: alu_e = 1'b1;
    endcase
  end
  sync_arith_iter_core #(.M(M)) u_core (
    .clk(clk),
    .i_reset(i_reset),
    .start_i(iter_start),
    .step_i(state_q == BUSY && !i_abort),
    .op_i(iop),
    .a_i(iarg_A),
    .b_i(iarg_B),
    .done_o(iter_done),
    .result_o(iter_res),
    .hi_o(iter_hi)
  );
  always_comb begin
    state_d = state_q;
    result_d = result_q;
    status_d = status_q;
    valid_d = 1'b0;
    if (state_q == IDLE) begin
      if (iter_start) begin
        state_d = BUSY;
      end else if (accept) begin
        valid_d = 1'b1;
        result_d = alu_r;
        status_d = pack_status(alu_r == '0, alu_c, alu_v, alu_e);
      end
    end else if (i_abort) begin
      state_d = IDLE;
    end else if (iter_done) begin
      state_d = IDLE;
      valid_d = 1'b1;
      result_d = iter_res;
      status_d = pack_status(iter_res == '0, 1'b0, iter_hi, 1'b0);
    end
  end
  always_ff @(posedge clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= IDLE;
      result_q <= '0;
      status_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      result_q <= result_d;
      status_q <= status_d;
      valid_q <= valid_d;
    end
  end
  assign o_ready = state_q == IDLE;
  assign o_valid = valid_q;
  assign o_result = result_q;
  assign o_status = status_q;
endmodule

// File: tb/tb_sync_arith_unit_mc.sv
// tb_sync_arith_unit_mc: vector table, random reference-model and corner-sequence bench for sync_arith_unit_mc
module tb_sync_arith_unit_mc;
  localparam int M = 32;
`ifdef SYNC_ARITH_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif
  localparam longint SMAX = 2147483647;
  localparam longint SMIN = -SMAX - 1;
  logic clk = 1'b0, i_reset = 1'b1, i_valid = 1'b0, i_abort = 1'b0;
  logic [M-1:0] iarg_A = '0, iarg_B = '0;
  logic [3:0] iop = '0;
  logic o_ready, o_valid;
  logic [M-1:0] o_result;
  logic [3:0] o_status;
  int total = 0, bad = 0;
  typedef struct {
    logic [3:0] op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic [3:0] st;
    int lat;
  } vec_t;
  vec_t vecs[$];

  sync_arith_unit_mc #(.M(M)) dut (
    .clk(clk), .i_reset(i_reset), .iarg_A(iarg_A), .iarg_B(iarg_B), .iop(iop),
    .i_valid(i_valid), .i_abort(i_abort), .o_ready(o_ready), .o_valid(o_valid),
    .o_result(o_result), .o_status(o_status)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // reference: results straight from integer arithmetic on the opcode definitions
  task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] r, output logic [3:0] st, output int lat);
    longint sa, sb, s;
    logic [63:0] p;
    logic c, v, e;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    c = 1'b0; v = 1'b0; e = 1'b0; lat = 1; r = '0;
    case (op)
      4'd0: begin p = {32'b0, a} + {32'b0, b}; r = p[31:0]; c = p[32]; s = sa + sb; v = s > SMAX || s < SMIN; end
      4'd1: begin r = a - b; c = a < b; s = sa - sb; v = s > SMAX || s < SMIN; end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: begin p = {32'b0, a} << b[4:0]; r = p[31:0]; c = p[32]; end
      4'd6: r = a >> b[4:0];
      4'd7: begin p = {32'b0, a} * {32'b0, b}; r = p[31:0]; v = p[63:32] != 0; lat = M + 1; end
      4'd8, 4'd9: begin
        if (DIV_EN && b != 0) begin r = (op == 4'd8) ? a / b : a % b; lat = M + 1; end
        else e = 1'b1;
      end
      default: e = 1'b1;
    endcase
    if (e) begin r = '1; c = 1'b0; v = 1'b0; end
    st = {e, v, c, r == 0};
  endtask

  // presents one request when ready; returns at the negedge of the cycle after acceptance
  task automatic start_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int k;
    k = 0;
    @(negedge clk);
    while (!o_ready && k < 100) begin @(negedge clk); k++; end
    iop = op; iarg_A = a; iarg_B = b; i_valid = 1'b1;
    @(negedge clk);
    i_valid = 1'b0;
  endtask

  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] r, output logic [3:0] st, output int lat, output int rdy_bad);
    rdy_bad = 0;
    start_op(op, a, b);
    lat = 1;
    while (!o_valid && lat < 100) begin
      if (o_ready) rdy_bad++;
      iarg_A = $urandom; iarg_B = $urandom; iop = 4'($urandom);
      @(negedge clk);
      lat++;
    end
    r = o_result;
    st = o_status;
  endtask

  initial begin
    logic [31:0] r, er;
    logic [3:0] st, est;
    int lat, elat, rb, pulses, first;
    logic [3:0] op;
    logic [31:0] a, b;
    vecs.push_back('{4'd0, 32'd15, 32'd3, 32'd18, 4'b0000, 1});
    vecs.push_back('{4'd0, 32'h7FFFFFFF, 32'd1, 32'h80000000, 4'b0100, 1});
    vecs.push_back('{4'd1, 32'd3, 32'd5, 32'hFFFFFFFE, 4'b0010, 1});
    vecs.push_back('{4'd0, 32'hFFFFFFFF, 32'd1, 32'h0, 4'b0011, 1});
    vecs.push_back('{4'd1, 32'h80000000, 32'd1, 32'h7FFFFFFF, 4'b0100, 1});
    vecs.push_back('{4'd2, 32'hF0F0, 32'hFF00, 32'hF000, 4'b0000, 1});
    vecs.push_back('{4'd3, 32'h0, 32'h0, 32'h0, 4'b0001, 1});
    vecs.push_back('{4'd4, 32'hA5, 32'hA5, 32'h0, 4'b0001, 1});
    vecs.push_back('{4'd5, 32'h80000001, 32'd1, 32'h2, 4'b0010, 1});
    vecs.push_back('{4'd5, 32'd1, 32'd32, 32'd1, 4'b0000, 1});
    vecs.push_back('{4'd6, 32'h80000000, 32'd31, 32'd1, 4'b0000, 1});
    vecs.push_back('{4'd7, 32'd15, 32'd3, 32'd45, 4'b0000, 33});
    vecs.push_back('{4'd7, 32'h10000, 32'h10000, 32'h0, 4'b0101, 33});
    vecs.push_back('{4'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1, 4'b0100, 33});
    vecs.push_back('{4'd15, 32'd1, 32'd2, 32'hFFFFFFFF, 4'b1000, 1});
    vecs.push_back('{4'd10, 32'd1, 32'd2, 32'hFFFFFFFF, 4'b1000, 1});
    vecs.push_back('{4'd8, 32'd15, 32'd0, 32'hFFFFFFFF, 4'b1000, 1});
`ifdef SYNC_ARITH_DIV_EN
    vecs.push_back('{4'd8, 32'd15, 32'd3, 32'd5, 4'b0000, 33});
    vecs.push_back('{4'd9, 32'd15, 32'd4, 32'd3, 4'b0000, 33});
    vecs.push_back('{4'd8, 32'd7, 32'd9, 32'd0, 4'b0001, 33});
    vecs.push_back('{4'd9, 32'hFFFFFFFF, 32'd16, 32'd15, 4'b0000, 33});
`else
    vecs.push_back('{4'd8, 32'd15, 32'd3, 32'hFFFFFFFF, 4'b1000, 1});
    vecs.push_back('{4'd9, 32'd15, 32'd4, 32'hFFFFFFFF, 4'b1000, 1});
`endif
    #3 i_reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst result", o_result, 0);
    chk("rst status", o_status, 0);
    chk("rst valid", o_valid, 0);
    i_reset = 1'b1;
    @(negedge clk);
    chk("rst ready", o_ready, 1);

    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, r, st, lat, rb);
      chk($sformatf("vec%0d result", i), r, vecs[i].r);
      chk($sformatf("vec%0d status", i), st, vecs[i].st);
      chk($sformatf("vec%0d latency", i), lat, vecs[i].lat);
      if (vecs[i].lat > 1) chk($sformatf("vec%0d busy ready", i), rb, 0);
    end

    for (int i = 0; i < 150; i++) begin
      op = 4'($urandom_range(0, 15));
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      model(op, a, b, er, est, elat);
      run_op(op, a, b, r, st, lat, rb);
      chk($sformatf("rnd%0d op%0d result", i, op), r, er);
      chk($sformatf("rnd%0d op%0d status", i, op), st, est);
      chk($sformatf("rnd%0d op%0d latency", i, op), lat, elat);
      chk($sformatf("rnd%0d busy ready", i), rb, 0);
    end

    // back-to-back single-cycle requests, then hold
    @(negedge clk);
    iop = 4'd0; iarg_A = 32'd1; iarg_B = 32'd2; i_valid = 1'b1;
    @(negedge clk);
    chk("b2b first valid", o_valid, 1);
    chk("b2b first result", o_result, 3);
    iop = 4'd4; iarg_A = 32'hF; iarg_B = 32'h3;
    @(negedge clk);
    i_valid = 1'b0;
    chk("b2b second valid", o_valid, 1);
    chk("b2b second result", o_result, 32'hC);
    @(negedge clk);
    chk("hold valid low", o_valid, 0);
    chk("hold result", o_result, 32'hC);

    // requests while busy are dropped
    start_op(4'd7, 32'd15, 32'd3);
    iop = 4'd0; iarg_A = 32'd1; iarg_B = 32'd1; i_valid = 1'b1;
    pulses = 0; first = 0; r = '0;
    for (int k = 1; k <= 40; k++) begin
      if (o_valid) begin pulses++; if (first == 0) first = k; r = o_result; i_valid = 1'b0; end
      @(negedge clk);
    end
    i_valid = 1'b0;
    chk("busy ignore pulses", pulses, 1);
    chk("busy ignore cycle", first, 33);
    chk("busy ignore result", r, 45);

    // abort mid-operation
    run_op(4'd0, 32'd15, 32'd3, r, st, lat, rb);
    start_op(4'd7, 32'd15, 32'd3);
    pulses = 0;
    repeat (9) begin @(negedge clk); if (o_valid) pulses++; end
    i_abort = 1'b1;
    @(negedge clk);
    i_abort = 1'b0;
    chk("abort ready", o_ready, 1);
    chk("abort valid", o_valid, 0);
    chk("abort result", o_result, 18);
    repeat (40) begin @(negedge clk); if (o_valid) pulses++; end
    chk("abort pulses", pulses, 0);

    // abort on the completion cycle wins
    start_op(4'd7, 32'd15, 32'd3);
    repeat (31) @(negedge clk);
    i_abort = 1'b1;
    @(negedge clk);
    i_abort = 1'b0;
    chk("abort last valid", o_valid, 0);
    chk("abort last ready", o_ready, 1);
    chk("abort last result", o_result, 18);

    // abort in idle is ignored
    @(negedge clk);
    iop = 4'd0; iarg_A = 32'd2; iarg_B = 32'd2; i_valid = 1'b1; i_abort = 1'b1;
    @(negedge clk);
    i_valid = 1'b0; i_abort = 1'b0;
    chk("idle abort valid", o_valid, 1);
    chk("idle abort result", o_result, 4);

    // reset during an iterative op
    run_op(4'd0, 32'd15, 32'd3, r, st, lat, rb);
    start_op(DIV_EN ? 4'd8 : 4'd7, 32'd15, 32'd3);
    repeat (4) @(negedge clk);
    #2 i_reset = 1'b0;
    #1;
    chk("busy rst result", o_result, 0);
    chk("busy rst status", o_status, 0);
    chk("busy rst valid", o_valid, 0);
    chk("busy rst ready", o_ready, 1);
    @(negedge clk);
    i_reset = 1'b1;
    pulses = 0;
    repeat (40) begin @(negedge clk); if (o_valid) pulses++; end
    chk("busy rst pulses", pulses, 0);
    chk("busy rst ready after", o_ready, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sync_arith_unit_mc.md
SYNC_ARITH_UNIT_MC -- requirements
Module: sync_arith_unit_mc

Interface
REQ-001 Parameter M, default 32, meaning operand/result width; SHALL be a power of two, 8..64.
REQ-002 clk  input  1  rising-edge clock; single clock domain.
REQ-003 i_reset  input  1  asynchronous, active-low reset.
REQ-004 iarg_A  input  M  operand A.
REQ-005 iarg_B  input  M  operand B.
REQ-006 iop  input  4  opcode.
REQ-007 i_valid  input  1  operation request, qualified by o_ready.
REQ-008 i_abort  input  1  synchronous cancel of an in-flight iterative operation.
REQ-009 o_ready  output  1  unit can accept a request this cycle.
REQ-010 o_valid  output  1  one-cycle pulse: o_result/o_status hold a new completed result.
REQ-011 o_result  output  M  registered result.
REQ-012 o_status  output  4  registered flags: [0] Z zero, [1] C carry/borrow, [2] V overflow, [3] E error.

Function
REQ-013 Request SHALL be accepted only on a rising edge with i_valid=1 and o_ready=1; i_valid with o_ready=0 SHALL be ignored, not queued.
REQ-014 Opcodes: 0 ADD, 1 SUB (A-B), 2 AND, 3 OR, 4 XOR, 5 SHL A by B[log2(M)-1:0], 6 SHR logical, 7 MUL unsigned (low M bits), 8 DIV unsigned quotient, 9 REM unsigned remainder; 10..15 invalid.
REQ-015 FSM states IDLE and BUSY; o_ready=1 exactly in IDLE.
REQ-016 Single-cycle ops (0..6, invalid, div-by-zero) accepted in cycle n SHALL give o_valid=1 in cycle n+1; state stays IDLE, so back-to-back acceptance every cycle is permitted.
REQ-017 MUL/DIV/REM (nonzero divisor) accepted in cycle n SHALL go BUSY, take M iterations (shift-add / restoring), o_ready=0 in cycles n+1..n+M, o_valid=1 with result in cycle n+M+1, FSM back in IDLE that cycle.
REQ-018 Operands and opcode SHALL be latched at acceptance; input changes during BUSY have no effect.
REQ-019 Z=1 iff o_result==0, for every op.
REQ-020 C: ADD carry-out of bit M-1; SUB borrow (A<B unsigned); SHL last bit shifted out; 0 for other ops.
REQ-021 V: ADD/SUB signed two's-complement overflow; MUL 1 iff the upper M bits of the 2M-bit product are nonzero; 0 otherwise.
REQ-022 E=1 with o_result all-ones and Z=C=V=0 for invalid opcode, and for DIV/REM with B==0.
REQ-023 o_result/o_status SHALL hold their last value between o_valid pulses.
REQ-024 i_abort=1 while BUSY SHALL return to IDLE on the next edge with no o_valid and outputs unchanged; i_abort in IDLE ignored; i_abort has priority over iteration completion in the same cycle.

Reset
REQ-025 i_reset=0 SHALL immediately force IDLE, iteration counter 0, o_valid=0, o_result=0, o_status=0; o_ready=1 once deasserted.
REQ-026 Reset during BUSY SHALL discard the operation; no o_valid after release.

Configuration
REQ-027 Macro SYNC_ARITH_DIV_EN: defined -> DIV/REM implemented per REQ-017/022; undefined -> divider logic absent, opcodes 8 and 9 treated as invalid (REQ-022, single-cycle).

Structure
REQ-028 Package sync_arith_pkg SHALL hold the opcode enum, status bit index constants and FSM state typedef.
REQ-029 Iterative MUL/DIV datapath SHALL be sub-module sync_arith_iter_core (start, op, operands in; done, result, high-half flag out); top holds FSM, handshake, single-cycle ALU, flags.

Verification (M=32)
REQ-030 ADD A=15 B=3 accepted cycle n -> cycle n+1 o_valid=1, o_result=18, o_status=0000.
REQ-031 ADD A=0x7FFFFFFF B=1 -> o_result=0x80000000, V=1, C=0; SUB A=3 B=5 -> 0xFFFFFFFE, C=1.
REQ-032 MUL A=15 B=3 -> o_ready=0 for 32 cycles, o_valid cycle n+33, o_result=45; MUL 0x10000*0x10000 -> result 0, Z=1, V=1.
REQ-033 DIV 15/3 -> 5 at n+33; REM 15%4 -> 3; DIV 15/0 -> n+1, o_result=0xFFFFFFFF, E=1; without SYNC_ARITH_DIV_EN DIV 15/3 -> E=1 at n+1.
REQ-034 During MUL BUSY: i_valid with ADD ignored (no extra o_valid); i_abort at n+10 -> IDLE at n+11, no o_valid, o_result unchanged.
REQ-035 i_reset=0 at n+5 of a DIV -> outputs 0, o_ready=1 after release, no o_valid; iop=4'b1111 -> E=1, o_result=0xFFFFFFFF.
